vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA controller in the lab top level.
- Derives the pixel-rate strobe from the 50 MHz system clock and generates hs, vs and blank from fully parametrised horizontal and vertical timing.
- Sync polarity is configurable.
- Adds line/frame start pulses, a frame counter, and an optional sync/blank delay pipe that aligns sync to multi-cycle sprite-ROM colour paths.

Parameters:
- CLK_DIV, 2: Clk cycles per pixel; legal range 1..16.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- HS_POL, 0: active level of hs.
- VS_POL, 0: active level of vs.
- CW, 10: width of the DrawX and DrawY counters; must hold H_TOTAL-1 and V_TOTAL-1.
- PIPE_DEPTH, 2: sync/blank delay in pixels; used only when VGA_TIMING_PIPE_EN is defined.

Ports:
- Clk, in, 1: system clock (50 MHz).
- Reset_n, in, 1: asynchronous, active-low reset.
- En, in, 1: run enable; when low, all counters freeze.
- pixel_ce, out, 1: one-Clk strobe every CLK_DIV cycles; all counters advance only on this strobe.
- pixel_clk, out, 1: registered divided clock, high for the first ceil(CLK_DIV/2) cycles of each pixel period; drives the VGA DAC and sprite ROM clocks.
- hs, out, 1: horizontal sync, at HS_POL level when active.
- vs, out, 1: vertical sync, at VS_POL level when active.
- blank, out, 1: active low; 1 = visible region.
- sync, out, 1: constant 0 (composite sync unused).
- DrawX, out, CW: current pixel column.
- DrawY, out, CW: current line.
- line_start, out, 1: one-Clk pulse coincident with pixel_ce when DrawX wraps to 0.
- frame_start, out, 1: one-Clk pulse coincident with pixel_ce when (DrawX, DrawY) wraps to (0, 0).
- frame_cnt, out, 16: number of completed frames, wrapping.

Behaviour:
- Totals: H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP. V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP.
- Reset values (asynchronous, on Reset_n low):
  - divider = 0.
  - DrawX = 0, DrawY = 0, frame_cnt = 0.
  - pixel_ce = 0, pixel_clk = 0.
  - hs = ~HS_POL, vs = ~VS_POL.
  - blank = 0, line_start = 0, frame_start = 0.
- Reset release: the first pixel_ce occurs CLK_DIV Clk edges after Reset_n deasserts.
- Divider: counts 0..CLK_DIV-1. pixel_ce is registered high on the Clk where the divider equals CLK_DIV-1. When CLK_DIV = 1, pixel_ce = En and pixel_clk = 0.
- Counter advance, on pixel_ce & En:
  - DrawX increments. When DrawX = H_TOTAL-1, DrawX goes to 0 and DrawY increments.
  - When DrawY = V_TOTAL-1 at that wrap, DrawY goes to 0 and frame_cnt increments, wrapping 0xFFFF to 0.
- Sync and blank decode: hs, vs and blank are registered from the next-count values, so they change on the same Clk edge as DrawX/DrawY. They never glitch and are always coherent with DrawX/DrawY.
  - hs active iff H_ACTIVE+H_FP <= DrawX < H_ACTIVE+H_FP+H_SYNC.
  - vs active iff V_ACTIVE+V_FP <= DrawY < V_ACTIVE+V_FP+V_SYNC. vs changes only at line wrap.
  - blank = (DrawX < H_ACTIVE) & (DrawY < V_ACTIVE).
- line_start and frame_start are asserted for the single Clk on which the wrapped counter value is first presented.
- En low: divider and counters hold, pixel_ce stays 0, outputs hold their values. Raising En resumes from the held state with no skipped pixel.
- Reset_n asserted mid-frame: every output goes immediately to its reset value, with no waiting on a Clk edge.

Optional Feature:
- Macro: VGA_TIMING_PIPE_EN.
- Defined: hs, vs, blank, line_start and frame_start pass through a PIPE_DEPTH-stage shift register that shifts only on pixel_ce & En.
  - Stages reset to the inactive levels: ~HS_POL, ~VS_POL, 0, 0, 0.
  - DrawX and DrawY are not delayed, so ROM addressing leads the sync signals by PIPE_DEPTH pixels.
  - PIPE_DEPTH = 0 is legal and equals the undefined case.
- Undefined: no delay stages; PIPE_DEPTH is ignored.

Decomposition:
- Package vga_timing_pkg:
  - typedef struct vga_timing_t {h_active, h_fp, h_sync, h_bp, v_active, v_fp, v_sync, v_bp}.
  - Constant VGA_640x480 with the default values.
  - Functions h_total() and v_total().
- Sub-module pixel_ce_gen: the divider producing pixel_ce and pixel_clk, parametrised by CLK_DIV. It is shared with the sprite frame logic.

Test Plan:
- Bench timing for all scenarios: H 8/2/3/3 (H_TOTAL 16), V 4/1/2/1 (V_TOTAL 8), CLK_DIV = 2.
- Reset: release Reset_n with En = 1 → first pixel_ce on the 2nd Clk; DrawX steps 0→1 on that edge; hs = 1, vs = 1, blank = 1 thereafter.
- Line timing:
  - hs low exactly for DrawX 10..12, i.e. 3 pixel_ce = 6 Clk.
  - blank low for DrawX 8..15.
  - line_start pulses once per 32 Clk.
- Frame timing:
  - vs low for DrawY 5..6.
  - frame_start fires at DrawX = 0, DrawY = 0 every 256 Clk.
  - frame_cnt = 3 after 768 Clk.
- Freeze: drop En at DrawX = 5 for 10 Clk → DrawX holds 5 and pixel_ce stays 0; on resume the next value is 6.
- Polarity and reset: with HS_POL = 1, VS_POL = 1, hs is high only at DrawX 10..12. Assert Reset_n at DrawY = 3 → same-cycle return to DrawX = 0, DrawY = 0, hs = 0, blank = 0.
- Pipe: with VGA_TIMING_PIPE_EN defined and PIPE_DEPTH = 2, hs falls when DrawX = 12 and rises when DrawX = 15, and blank lags DrawX by 2 pixels.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// ----------------------------------------------------------------------------
// vga_timing_pkg : shared timing record, 640x480 default and total helpers
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package vga_timing_pkg;

    typedef struct packed {
        logic [15:0] h_active;
        logic [15:0] h_fp;
        logic [15:0] h_sync;
        logic [15:0] h_bp;
        logic [15:0] v_active;
        logic [15:0] v_fp;
        logic [15:0] v_sync;
        logic [15:0] v_bp;
    } vga_timing_t;

    // Per-pixel sync record; the optional delay pipe carries one per stage.
    typedef struct packed {
        logic hs;
        logic vs;
        logic blank;
        logic line_start;
        logic frame_start;
    } sync_bus_t;

    localparam vga_timing_t VGA_640x480 = '{
        h_active: 16'd640,
        h_fp:     16'd16,
        h_sync:   16'd96,
        h_bp:     16'd48,
        v_active: 16'd480,
        v_fp:     16'd10,
        v_sync:   16'd2,
        v_bp:     16'd33
    };

    function automatic int h_total(input vga_timing_t t);
        return int'(t.h_active) + int'(t.h_fp) + int'(t.h_sync) + int'(t.h_bp);
    endfunction

    function automatic int v_total(input vga_timing_t t);
        return int'(t.v_active) + int'(t.v_fp) + int'(t.v_sync) + int'(t.v_bp);
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_timing_gen_pixel_ce_gen.sv
// ----------------------------------------------------------------------------
// pixel_ce_gen : divides the system clock into a pixel strobe and pixel clock
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pixel_ce_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick,
    output logic pixel_ce,
    output logic pixel_clk
);

    generate
        if (CLK_DIV == 1) begin : g_bypass
            assign tick      = en;
            assign pixel_clk = 1'b0;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pixel_ce <= 1'b0;
                end else begin
                    pixel_ce <= en;
                end
            end
        end else begin : g_div
            localparam int            DW   = $clog2(CLK_DIV);
            localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);
            localparam logic [DW-1:0] HIGH = DW'((CLK_DIV + 1) / 2);

            logic [DW-1:0] div;
            logic [DW-1:0] div_nxt;

            // tick marks the edge on which counters advance; pixel_ce shows it a cycle later.
            assign tick = en & (div == LAST);

            always_comb begin
                div_nxt = div;
                if (en) begin
                    div_nxt = tick ? '0 : div + DW'(1);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    div       <= '0;
                    pixel_ce  <= 1'b0;
                    pixel_clk <= 1'b0;
                end else begin
                    div      <= div_nxt;
                    pixel_ce <= tick;
                    if (en) begin
                        pixel_clk <= (div_nxt < HIGH);
                    end
                end
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen : parametrised VGA sync/blank/counter generator
// VGA_TIMING_PIPE_EN delays sync/blank/start pulses by PIPE_DEPTH pixels. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int H_ACTIVE   = int'(VGA_640x480.h_active),
    parameter int H_FP       = int'(VGA_640x480.h_fp),
    parameter int H_SYNC     = int'(VGA_640x480.h_sync),
    parameter int H_BP       = int'(VGA_640x480.h_bp),
    parameter int V_ACTIVE   = int'(VGA_640x480.v_active),
    parameter int V_FP       = int'(VGA_640x480.v_fp),
    parameter int V_SYNC     = int'(VGA_640x480.v_sync),
    parameter int V_BP       = int'(VGA_640x480.v_bp),
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int CW         = 10,
    parameter int PIPE_DEPTH = 2
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          En,
    output logic          pixel_ce,
    output logic          pixel_clk,
    output logic          hs,
    output logic          vs,
    output logic          blank,
    output logic          sync,
    output logic [CW-1:0] DrawX,
    output logic [CW-1:0] DrawY,
    output logic          line_start,
    output logic          frame_start,
    output logic [15:0]   frame_cnt
);

    localparam vga_timing_t TIMING = '{
        h_active: 16'(H_ACTIVE),
        h_fp:     16'(H_FP),
        h_sync:   16'(H_SYNC),
        h_bp:     16'(H_BP),
        v_active: 16'(V_ACTIVE),
        v_fp:     16'(V_FP),
        v_sync:   16'(V_SYNC),
        v_bp:     16'(V_BP)
    };

    localparam int H_TOTAL = h_total(TIMING);
    localparam int V_TOTAL = v_total(TIMING);

    localparam logic [CW-1:0] X_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] Y_LAST = CW'(V_TOTAL - 1);

    localparam int HS_BEG = H_ACTIVE + H_FP;
    localparam int HS_END = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_BEG = V_ACTIVE + V_FP;
    localparam int VS_END = V_ACTIVE + V_FP + V_SYNC;

    localparam sync_bus_t IDLE = '{
        hs:          ~HS_POL,
        vs:          ~VS_POL,
        blank:       1'b0,
        line_start:  1'b0,
        frame_start: 1'b0
    };

`ifdef VGA_TIMING_PIPE_EN
    localparam bit PIPE_EN = 1'b1;
`else
    localparam bit PIPE_EN = 1'b0;
`endif
    localparam int DEPTH = PIPE_EN ? PIPE_DEPTH : 0;

    logic          tick;
    logic          x_wrap;
    logic          y_wrap;
    logic [CW-1:0] x_nxt;
    logic [CW-1:0] y_nxt;
    sync_bus_t     base;
    sync_bus_t     base_nxt;
    sync_bus_t     tap;

    pixel_ce_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_ce_gen (
        .clk       (Clk),
        .rst_n     (Reset_n),
        .en        (En),
        .tick      (tick),
        .pixel_ce  (pixel_ce),
        .pixel_clk (pixel_clk)
    );

    // Decode from the next count so sync/blank move on the same edge as DrawX/DrawY.
    always_comb begin
        x_wrap = (DrawX == X_LAST);
        y_wrap = (DrawY == Y_LAST);
        x_nxt  = x_wrap ? '0 : DrawX + CW'(1);
        y_nxt  = DrawY;
        if (x_wrap) begin
            y_nxt = y_wrap ? '0 : DrawY + CW'(1);
        end

        base_nxt.hs          = (int'(x_nxt) >= HS_BEG && int'(x_nxt) < HS_END) ? HS_POL : ~HS_POL;
        base_nxt.vs          = (int'(y_nxt) >= VS_BEG && int'(y_nxt) < VS_END) ? VS_POL : ~VS_POL;
        base_nxt.blank       = (int'(x_nxt) < H_ACTIVE) && (int'(y_nxt) < V_ACTIVE);
        base_nxt.line_start  = x_wrap;
        base_nxt.frame_start = x_wrap & y_wrap;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            DrawX     <= '0;
            DrawY     <= '0;
            frame_cnt <= 16'd0;
            base      <= IDLE;
        end else if (tick) begin
            DrawX <= x_nxt;
            DrawY <= y_nxt;
            base  <= base_nxt;
            if (x_wrap && y_wrap) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    generate
        if (DEPTH == 0) begin : g_no_pipe
            assign tap = base;
        end else begin : g_pipe
            sync_bus_t stage [DEPTH];

            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage[i] <= IDLE;
                    end
                end else if (tick) begin
                    stage[0] <= base;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign tap = stage[DEPTH-1];
        end
    endgenerate

    // Start flags are held per pixel; gating with pixel_ce trims them to one Clk.
    assign hs          = tap.hs;
    assign vs          = tap.vs;
    assign blank       = tap.blank;
    assign line_start  = tap.line_start & pixel_ce;
    assign frame_start = tap.frame_start & pixel_ce;
    assign sync        = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_gen : scoreboard bench, 16x8 total timing at CLK_DIV 2
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_vga_timing_gen;

    localparam int CLK_DIV = 2;
    localparam int HT      = 16;
    localparam int VT      = 8;
`ifdef VGA_TIMING_PIPE_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 0;
`endif

    logic Clk     = 1'b0;
    logic Reset_n = 1'b0;
    logic En      = 1'b1;

    logic       pce0, pclk0, hs0, vs0, blank0, sync0, ls0, fs0;
    logic [7:0] x0, y0;
    logic [15:0] fc0;
    logic       pce1, pclk1, hs1, vs1, blank1, sync1, ls1, fs1;
    logic [7:0] x1, y1;
    logic [15:0] fc1;

    vga_timing_gen #(
        .CLK_DIV(CLK_DIV), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(8), .PIPE_DEPTH(2)
    ) dut0 (
        .Clk(Clk), .Reset_n(Reset_n), .En(En),
        .pixel_ce(pce0), .pixel_clk(pclk0), .hs(hs0), .vs(vs0), .blank(blank0),
        .sync(sync0), .DrawX(x0), .DrawY(y0), .line_start(ls0),
        .frame_start(fs0), .frame_cnt(fc0)
    );

    vga_timing_gen #(
        .CLK_DIV(CLK_DIV), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(8), .PIPE_DEPTH(2)
    ) dut1 (
        .Clk(Clk), .Reset_n(Reset_n), .En(En),
        .pixel_ce(pce1), .pixel_clk(pclk1), .hs(hs1), .vs(vs1), .blank(blank1),
        .sync(sync1), .DrawX(x1), .DrawY(y1), .line_start(ls1),
        .frame_start(fs1), .frame_cnt(fc1)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit ce;
        bit pclk;
        bit hs_act;
        bit vs_act;
        bit blank;
        bit ls;
        bit fs;
        int x;
        int y;
        int fc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, obs, want, $time);
        end
    endtask

    // Reference model: pixels elapsed since reset, decoded arithmetically.
    bit started = 1'b0;
    int m_div   = 0;
    int pix     = 0;
    bit m_ce    = 1'b0;

    function automatic exp_t predict();
        exp_t e;
        int   d, hx, vy;
        e.ce     = m_ce;
        e.pclk   = started && (m_div == 0);
        e.x      = pix % HT;
        e.y      = (pix / HT) % VT;
        e.fc     = (pix / (HT * VT)) % 65536;
        e.hs_act = 1'b0;
        e.vs_act = 1'b0;
        e.blank  = 1'b0;
        e.ls     = 1'b0;
        e.fs     = 1'b0;
        d = pix - DEPTH;
        if (d >= 1) begin
            hx       = d % HT;
            vy       = (d / HT) % VT;
            e.hs_act = (hx >= 10) && (hx < 13);
            e.vs_act = (vy >= 5) && (vy < 7);
            e.blank  = (hx < 8) && (vy < 4);
            e.ls     = m_ce && (hx == 0);
            e.fs     = m_ce && (hx == 0) && (vy == 0);
        end
        return e;
    endfunction

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            started = 1'b0;
            m_div   = 0;
            pix     = 0;
            m_ce    = 1'b0;
            q.delete();
            if (Clk) q.push_back(predict());
        end else begin
            m_ce = 1'b0;
            if (En) begin
                started = 1'b1;
                if (m_div == CLK_DIV - 1) begin
                    m_div = 0;
                    pix++;
                    m_ce = 1'b1;
                end else begin
                    m_div++;
                end
            end
            q.push_back(predict());
        end
    end

    int cyc    = 0;
    int last_ls = -1;
    int last_fs = -1;
    int hs_run  = 0;

    always @(negedge Clk) begin
        exp_t e;
        cyc++;
        if (q.size() > 0) begin
            e = q.pop_front();
            check_eq("pixel_ce", pce0, e.ce);
            check_eq("pixel_clk", pclk0, e.pclk);
            check_eq("DrawX", x0, e.x);
            check_eq("DrawY", y0, e.y);
            check_eq("frame_cnt", fc0, e.fc);
            check_eq("hs", hs0, e.hs_act ? 0 : 1);
            check_eq("vs", vs0, e.vs_act ? 0 : 1);
            check_eq("blank", blank0, e.blank);
            check_eq("line_start", ls0, e.ls);
            check_eq("frame_start", fs0, e.fs);
            check_eq("sync", sync0, 0);
            check_eq("hs_pol1", hs1, e.hs_act ? 1 : 0);
            check_eq("vs_pol1", vs1, e.vs_act ? 1 : 0);
            check_eq("DrawX_pol1", x1, e.x);
            check_eq("blank_pol1", blank1, e.blank);
        end
        if (!Reset_n || !En) begin
            last_ls = -1;
            last_fs = -1;
            hs_run  = -1000;
        end else begin
            if (ls0) begin
                if (last_ls >= 0) check_eq("ls_period", cyc - last_ls, 32);
                last_ls = cyc;
            end
            if (fs0) begin
                if (last_fs >= 0) check_eq("fs_period", cyc - last_fs, 256);
                check_eq("fs_x", x0, DEPTH);
                check_eq("fs_y", y0, 0);
                last_fs = cyc;
            end
            if (hs0 == 1'b0) begin
                hs_run++;
            end else begin
                if (hs_run > 0) check_eq("hs_width", hs_run, 6);
                hs_run = 0;
            end
        end
    end

    initial begin
        int n;
        repeat (3) @(negedge Clk);
        #2 Reset_n = 1'b1;

        @(posedge Clk); #1;
        check_eq("rel_ce_edge1", pce0, 0);
        check_eq("rel_x_edge1", x0, 0);
        @(posedge Clk); #1;
        check_eq("rel_ce_edge2", pce0, 1);
        check_eq("rel_x_edge2", x0, 1);
        check_eq("rel_hs", hs0, 1);
        check_eq("rel_vs", vs0, 1);
        repeat (766) @(posedge Clk);
        #1 check_eq("fc_after_768", fc0, 3);

        // Freeze at DrawX = 5 for 10 Clk.
        n = 0;
        @(negedge Clk);
        while (!(x0 == 8'd5 && pce0) && n < 200) begin
            @(negedge Clk);
            n++;
        end
        check_eq("wait_x5", x0, 5);
        #1 En = 1'b0;
        repeat (10) begin
            @(negedge Clk);
            check_eq("freeze_x", x0, 5);
            check_eq("freeze_ce", pce0, 0);
        end
        #1 En = 1'b1;
        n = 0;
        @(negedge Clk);
        while (x0 == 8'd5 && n < 50) begin
            @(negedge Clk);
            n++;
        end
        check_eq("resume_x", x0, 6);

        // Asynchronous reset mid-frame at DrawY = 3.
        n = 0;
        while (y0 != 8'd3 && n < 1000) begin
            @(negedge Clk);
            n++;
        end
        check_eq("wait_y3", y0, 3);
        #2 Reset_n = 1'b0;
        #1;
        check_eq("arst_x", x0, 0);
        check_eq("arst_y", y0, 0);
        check_eq("arst_hs_pol1", hs1, 0);
        check_eq("arst_hs", hs0, 1);
        check_eq("arst_blank", blank0, 0);
        check_eq("arst_ce", pce0, 0);
        check_eq("arst_fc", fc0, 0);
        repeat (3) @(negedge Clk);
        #2 Reset_n = 1'b1;
        repeat (600) @(posedge Clk);
        @(negedge Clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
